bus_transfer_sequencer: RTL and testbench

//  Sequences one internal-bus micro-transfer per request for the 6502 register datapath.

---
 rtl/bus_transfer_sequencer_pkg.sv | 57 +++++
 rtl/bus_transfer_sequencer_if.sv | 31 +++
 rtl/bus_transfer_sequencer_req_check.sv | 44 ++++
 rtl/bus_transfer_sequencer.sv | 120 ++++++++++++
 tb/tb_bus_transfer_sequencer.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/bus_transfer_sequencer_pkg.sv
// Shared encodings for the internal-bus transfer sequencer: source codes,
// load-strobe bit positions and FSM state encoding.
package bus_ctl_pkg;

    localparam int DST_W   = 11;
    localparam int DB_EN_W = 8;
    localparam int SB_EN_W = 6;
    localparam int ADL_EN_W = 5;
    localparam int ADH_EN_W = 3;

    localparam logic [2:0] DB_NONE = 3'd0;
    localparam logic [2:0] DB_X    = 3'd1;
    localparam logic [2:0] DB_Y    = 3'd2;
    localparam logic [2:0] DB_DL   = 3'd3;
    localparam logic [2:0] DB_P    = 3'd4;
    localparam logic [2:0] DB_PCL  = 3'd5;
    localparam logic [2:0] DB_PCH  = 3'd6;
    localparam logic [2:0] DB_AC   = 3'd7;

    localparam logic [2:0] SB_NONE = 3'd0;
    localparam logic [2:0] SB_X    = 3'd1;
    localparam logic [2:0] SB_Y    = 3'd2;
    localparam logic [2:0] SB_ADD  = 3'd3;
    localparam logic [2:0] SB_AC   = 3'd4;
    localparam logic [2:0] SB_S    = 3'd5;

    localparam logic [2:0] ADL_NONE = 3'd0;
    localparam logic [2:0] ADL_DL   = 3'd1;
    localparam logic [2:0] ADL_ADD  = 3'd2;
    localparam logic [2:0] ADL_PCL  = 3'd3;
    localparam logic [2:0] ADL_S    = 3'd4;

    localparam logic [1:0] ADH_NONE = 2'd0;
    localparam logic [1:0] ADH_DL   = 2'd1;
    localparam logic [1:0] ADH_PCH  = 2'd2;

    localparam int DST_X         = 0;
    localparam int DST_Y         = 1;
    localparam int DST_AC        = 2;
    localparam int DST_AI_SB     = 3;
    localparam int DST_AI_ZERO   = 4;
    localparam int DST_BI_DB     = 5;
    localparam int DST_BI_INV_DB = 6;
    localparam int DST_BI_ADL    = 7;
    localparam int DST_S_SB      = 8;
    localparam int DST_PCLS_ADL  = 9;
    localparam int DST_PCHS_ADH  = 10;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DRIVE   = 3'd1,
        LATCH   = 3'd2,
        RELEASE = 3'd3,
        REJECT  = 3'd4
    } state_t;

endpackage

// File: rtl/bus_transfer_sequencer_if.sv
// Request handshake plus bus-enable / load-strobe outputs of the sequencer.
interface bus_transfer_sequencer_if;
    import bus_ctl_pkg::*;

    logic                req_valid;
    logic                req_ready;
    logic [2:0]          req_db_src;
    logic [2:0]          req_sb_src;
    logic [2:0]          req_adl_src;
    logic [1:0]          req_adh_src;
    logic [DST_W-1:0]    req_dst;
    logic [DB_EN_W-1:0]  db_en;
    logic [SB_EN_W-1:0]  sb_en;
    logic [ADL_EN_W-1:0] adl_en;
    logic [ADH_EN_W-1:0] adh_en;
    logic [DST_W-1:0]    load_stb;
    logic                busy;
    logic                done;
    logic                err;

    modport master (
        output req_valid, req_db_src, req_sb_src, req_adl_src, req_adh_src, req_dst,
        input  req_ready, db_en, sb_en, adl_en, adh_en, load_stb, busy, done, err
    );

    modport slave (
        input  req_valid, req_db_src, req_sb_src, req_adl_src, req_adh_src, req_dst,
        output req_ready, db_en, sb_en, adl_en, adh_en, load_stb, busy, done, err
    );

endinterface

// File: rtl/bus_transfer_sequencer_req_check.sv
// Combinational legality check of one bus micro-transfer request.
module bus_req_check
    import bus_ctl_pkg::*;
(
    input  logic [2:0]       db_src,
    input  logic [2:0]       sb_src,
    input  logic [2:0]       adl_src,
    input  logic [1:0]       adh_src,
    input  logic [DST_W-1:0] dst,
    output logic             illegal
);
    logic range_bad;
    logic dual_bad;
    logic mux_bad;
    logic float_bad;
    logic needs_sb;
    logic needs_db;
    logic needs_adl;

    always_comb begin
        range_bad = (sb_src > SB_S) || (adl_src > ADL_S) || (adh_src > ADH_PCH);

        // X and Y have a single output port, so they cannot feed DB and SB together
        dual_bad = ((db_src == DB_X) && (sb_src == SB_X)) ||
                   ((db_src == DB_Y) && (sb_src == SB_Y));

        mux_bad = (dst[DST_AI_SB] && dst[DST_AI_ZERO]) ||
                  (dst[DST_BI_DB] && dst[DST_BI_INV_DB]) ||
                  (dst[DST_BI_DB] && dst[DST_BI_ADL]) ||
                  (dst[DST_BI_INV_DB] && dst[DST_BI_ADL]);

        needs_sb  = dst[DST_AI_SB] || dst[DST_X] || dst[DST_Y] || dst[DST_S_SB] || dst[DST_AC];
        needs_db  = dst[DST_BI_DB] || dst[DST_BI_INV_DB];
        needs_adl = dst[DST_BI_ADL] || dst[DST_PCLS_ADL];

        float_bad = (needs_sb && (sb_src == SB_NONE)) ||
                    (needs_db && (db_src == DB_NONE)) ||
                    (needs_adl && (adl_src == ADL_NONE)) ||
                    (dst[DST_PCHS_ADH] && (adh_src == ADH_NONE));

        illegal = range_bad || dual_bad || mux_bad || float_bad;
    end

endmodule

// File: rtl/bus_transfer_sequencer.sv
// Sequences one drive/settle/latch/release bus micro-transfer per accepted request.
module bus_transfer_sequencer
    import bus_ctl_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    bus_transfer_sequencer_if.slave bus
);
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_t              state_reg;
    state_t              state_next;
    logic [3:0]          cnt_reg;
    logic [3:0]          cnt_next;
    logic [2:0]          db_src_reg;
    logic [2:0]          sb_src_reg;
    logic [2:0]          adl_src_reg;
    logic [1:0]          adh_src_reg;
    logic [DST_W-1:0]    dst_reg;
    logic                accept;
    logic                illegal;
    logic                en_active;
    logic [DB_EN_W-1:0]  db_en;
    logic [SB_EN_W-1:0]  sb_en;
    logic [ADL_EN_W-1:0] adl_en;
    logic [ADH_EN_W-1:0] adh_en;

    assign bus.req_ready = rst_n && (state_reg == IDLE);
    assign accept        = bus.req_valid && bus.req_ready;

    // Legality is judged on the fields being captured so the branch to
    // DRIVE or REJECT is taken at the accept edge.
    bus_req_check u_check (
        .db_src  (bus.req_db_src),
        .sb_src  (bus.req_sb_src),
        .adl_src (bus.req_adl_src),
        .adh_src (bus.req_adh_src),
        .dst     (bus.req_dst),
        .illegal (illegal)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            db_src_reg  <= '0;
            sb_src_reg  <= '0;
            adl_src_reg <= '0;
            adh_src_reg <= '0;
            dst_reg     <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                db_src_reg  <= bus.req_db_src;
                sb_src_reg  <= bus.req_sb_src;
                adl_src_reg <= bus.req_adl_src;
                adh_src_reg <= bus.req_adh_src;
                dst_reg     <= bus.req_dst;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    cnt_next   = '0;
                    state_next = illegal ? REJECT : DRIVE;
                end
            end
            DRIVE: begin
                if (cnt_reg == SETTLE_LAST) begin
                    state_next = LATCH;
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end
            LATCH:   state_next = RELEASE;
            RELEASE: state_next = IDLE;
            REJECT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign en_active = (state_reg == DRIVE) || (state_reg == LATCH);

    // Code 0 means "no driver", so bit 0 of every enable vector stays low.
    assign db_en[0]  = 1'b0;
    assign sb_en[0]  = 1'b0;
    assign adl_en[0] = 1'b0;
    assign adh_en[0] = 1'b0;

    for (genvar gi = 1; gi < DB_EN_W; gi++) begin : g_db
        assign db_en[gi] = en_active && (db_src_reg == 3'(gi));
    end
    for (genvar gi = 1; gi < SB_EN_W; gi++) begin : g_sb
        assign sb_en[gi] = en_active && (sb_src_reg == 3'(gi));
    end
    for (genvar gi = 1; gi < ADL_EN_W; gi++) begin : g_adl
        assign adl_en[gi] = en_active && (adl_src_reg == 3'(gi));
    end
    for (genvar gi = 1; gi < ADH_EN_W; gi++) begin : g_adh
        assign adh_en[gi] = en_active && (adh_src_reg == 2'(gi));
    end

    assign bus.db_en    = db_en;
    assign bus.sb_en    = sb_en;
    assign bus.adl_en   = adl_en;
    assign bus.adh_en   = adh_en;
    assign bus.load_stb = (state_reg == LATCH) ? dst_reg : '0;
    assign bus.busy     = (state_reg != IDLE);
    assign bus.done     = (state_reg == RELEASE);
    assign bus.err      = (state_reg == REJECT);

endmodule

// File: tb/tb_bus_transfer_sequencer.sv
// Scoreboard bench: the same request table is run against SETTLE_CYCLES=1 and =3 instances.
module tb_bus_transfer_sequencer;
    import bus_ctl_pkg::*;

    typedef struct {
        logic [2:0]  db;
        logic [2:0]  sb;
        logic [2:0]  adl;
        logic [1:0]  adh;
        logic [10:0] dst;
        bit          legal;
        bit          keep;
        bit          rst_mid;
    } req_t;

    typedef struct {
        int unsigned acc;
        bit          legal;
        logic [7:0]  db_en;
        logic [5:0]  sb_en;
        logic [4:0]  adl_en;
        logic [2:0]  adh_en;
        logic [10:0] dst;
    } exp_t;

    localparam int N_REQ = 20;

    req_t        tbl[N_REQ];
    logic        clk = 1'b0;
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    bit          blk_done[2];

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic req_t mk(input logic [2:0] db, input logic [2:0] sb, input logic [2:0] adl,
                                input logic [1:0] adh, input logic [10:0] dst,
                                input bit legal, input bit keep, input bit rst_mid);
        req_t r;
        r.db = db; r.sb = sb; r.adl = adl; r.adh = adh; r.dst = dst;
        r.legal = legal; r.keep = keep; r.rst_mid = rst_mid;
        return r;
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        localparam int unsigned S = (gi == 0) ? 1 : 3;

        logic rst_n = 1'b0;
        logic rst_q = 1'b0;
        bit   started = 1'b0;
        int   cur = 0;
        exp_t q[$];

        bus_transfer_sequencer_if bif ();

        bus_transfer_sequencer #(.SETTLE_CYCLES(S)) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bif)
        );

        always @(posedge clk) rst_q <= rst_n;

        // Driver
        initial begin
            bit got;
            bif.req_valid   = 1'b0;
            bif.req_db_src  = '0;
            bif.req_sb_src  = '0;
            bif.req_adl_src = '0;
            bif.req_adh_src = '0;
            bif.req_dst     = '0;
            rst_n = 1'b0;
            repeat (2) @(posedge clk);
            #1 started = 1'b1;
            @(posedge clk);
            #1 rst_n = 1'b1;
            @(posedge clk);
            #1;
            for (int i = 0; i < N_REQ; i++) begin
                cur             = i;
                bif.req_db_src  = tbl[i].db;
                bif.req_sb_src  = tbl[i].sb;
                bif.req_adl_src = tbl[i].adl;
                bif.req_adh_src = tbl[i].adh;
                bif.req_dst     = tbl[i].dst;
                bif.req_valid   = 1'b1;
                got = 1'b0;
                for (int w = 0; w < 40 && !got; w++) begin
                    @(negedge clk);
                    if (bif.req_ready) got = 1'b1;
                    @(posedge clk);
                    #1;
                end
                check_val($sformatf("s%0d accept req%0d", S, i), 32'(got), 32'd1);
                if (tbl[i].rst_mid) begin
                    bif.req_valid = 1'b0;
                    rst_n = 1'b0;
                    repeat (2) @(posedge clk);
                    #1 rst_n = 1'b1;
                end else if (!tbl[i].keep) begin
                    bif.req_valid = 1'b0;
                end
            end
            bif.req_valid = 1'b0;
            for (int w = 0; w < 40 && q.size() != 0; w++) @(posedge clk);
            repeat (3) @(posedge clk);
            check_val($sformatf("s%0d drain", S), 32'(q.size()), 32'd0);
            blk_done[gi] = 1'b1;
        end

        // Monitor / scoreboard
        initial begin
            int unsigned cyc;
            int unsigned d;
            exp_t        e;
            bit          exp_ready, exp_busy, pop, e_done, e_err;
            logic [7:0]  e_db;
            logic [5:0]  e_sb;
            logic [4:0]  e_adl;
            logic [2:0]  e_adh;
            logic [10:0] e_ld;
            cyc = 0;
            forever begin
                @(negedge clk);
                if (started) begin
                    cyc++;
                    if (!rst_q) q.delete();
                    exp_ready = rst_n && (q.size() == 0);
                    exp_busy  = (q.size() != 0);
                    e_db = '0; e_sb = '0; e_adl = '0; e_adh = '0; e_ld = '0;
                    e_done = 1'b0; e_err = 1'b0; pop = 1'b0;
                    if (q.size() != 0) begin
                        e = q[0];
                        d = cyc - e.acc;
                        if (!e.legal) begin
                            e_err = 1'b1;
                            pop   = 1'b1;
                        end else begin
                            if (d <= S + 1) begin
                                e_db = e.db_en; e_sb = e.sb_en; e_adl = e.adl_en; e_adh = e.adh_en;
                            end
                            if (d == S + 1) e_ld = e.dst;
                            if (d >= S + 2) begin
                                e_done = 1'b1;
                                pop    = 1'b1;
                            end
                        end
                    end
                    check_val($sformatf("s%0d c%0d db_en", S, cyc), 32'(bif.db_en), 32'(e_db));
                    check_val($sformatf("s%0d c%0d sb_en", S, cyc), 32'(bif.sb_en), 32'(e_sb));
                    check_val($sformatf("s%0d c%0d adl_en", S, cyc), 32'(bif.adl_en), 32'(e_adl));
                    check_val($sformatf("s%0d c%0d adh_en", S, cyc), 32'(bif.adh_en), 32'(e_adh));
                    check_val($sformatf("s%0d c%0d load_stb", S, cyc), 32'(bif.load_stb), 32'(e_ld));
                    check_val($sformatf("s%0d c%0d done", S, cyc), 32'(bif.done), 32'(e_done));
                    check_val($sformatf("s%0d c%0d err", S, cyc), 32'(bif.err), 32'(e_err));
                    check_val($sformatf("s%0d c%0d busy", S, cyc), 32'(bif.busy), 32'(exp_busy));
                    check_val($sformatf("s%0d c%0d req_ready", S, cyc), 32'(bif.req_ready), 32'(exp_ready));
                    if (pop) begin
                        $display("s%0d txn accepted at cycle %0d legal=%0d closed at cycle %0d",
                                 S, e.acc, e.legal, cyc);
                        void'(q.pop_front());
                    end
                    if (bif.req_valid && exp_ready) begin
                        e.acc    = cyc;
                        e.legal  = tbl[cur].legal;
                        e.db_en  = (e.legal && bif.req_db_src != 3'd0) ? (8'h01 << bif.req_db_src) : 8'h00;
                        e.sb_en  = (e.legal && bif.req_sb_src != 3'd0) ? (6'h01 << bif.req_sb_src) : 6'h00;
                        e.adl_en = (e.legal && bif.req_adl_src != 3'd0) ? (5'h01 << bif.req_adl_src) : 5'h00;
                        e.adh_en = (e.legal && bif.req_adh_src != 2'd0) ? (3'h1 << bif.req_adh_src) : 3'h0;
                        e.dst    = bif.req_dst;
                        q.push_back(e);
                    end
                end
            end
        end
    end

    initial begin
        // db, sb, adl, adh, dst, legal, keep valid high, reset mid-transfer
        tbl[0]  = mk(3'd0, 3'd4, 3'd0, 2'd0, 11'h008, 1'b1, 1'b0, 1'b1);
        tbl[1]  = mk(3'd0, 3'd4, 3'd0, 2'd0, 11'h008, 1'b1, 1'b0, 1'b0);
        tbl[2]  = mk(3'd3, 3'd0, 3'd3, 2'd2, 11'h620, 1'b1, 1'b0, 1'b0);
        tbl[3]  = mk(3'd1, 3'd1, 3'd0, 2'd0, 11'h000, 1'b0, 1'b0, 1'b0);
        tbl[4]  = mk(3'd0, 3'd0, 3'd0, 2'd0, 11'h001, 1'b0, 1'b0, 1'b0);
        tbl[5]  = mk(3'd3, 3'd0, 3'd1, 2'd0, 11'h0A0, 1'b0, 1'b0, 1'b0);
        tbl[6]  = mk(3'd0, 3'd0, 3'd0, 2'd0, 11'h000, 1'b1, 1'b0, 1'b0);
        tbl[7]  = mk(3'd0, 3'd6, 3'd0, 2'd0, 11'h000, 1'b0, 1'b0, 1'b0);
        tbl[8]  = mk(3'd0, 3'd0, 3'd5, 2'd0, 11'h000, 1'b0, 1'b0, 1'b0);
        tbl[9]  = mk(3'd0, 3'd0, 3'd0, 2'd3, 11'h000, 1'b0, 1'b0, 1'b0);
        tbl[10] = mk(3'd0, 3'd4, 3'd0, 2'd0, 11'h018, 1'b0, 1'b0, 1'b0);
        tbl[11] = mk(3'd2, 3'd2, 3'd0, 2'd0, 11'h000, 1'b0, 1'b0, 1'b0);
        tbl[12] = mk(3'd0, 3'd0, 3'd0, 2'd0, 11'h400, 1'b0, 1'b0, 1'b0);
        tbl[13] = mk(3'd0, 3'd0, 3'd0, 2'd0, 11'h010, 1'b1, 1'b0, 1'b0);
        tbl[14] = mk(3'd7, 3'd2, 3'd0, 2'd0, 11'h122, 1'b1, 1'b1, 1'b0);
        tbl[15] = mk(3'd1, 3'd3, 3'd2, 2'd1, 11'h484, 1'b1, 1'b1, 1'b0);
        tbl[16] = mk(3'd0, 3'd0, 3'd0, 2'd0, 11'h040, 1'b0, 1'b1, 1'b0);
        tbl[17] = mk(3'd6, 3'd0, 3'd0, 2'd0, 11'h040, 1'b1, 1'b1, 1'b0);
        tbl[18] = mk(3'd4, 3'd5, 3'd4, 2'd0, 11'h211, 1'b1, 1'b1, 1'b0);
        tbl[19] = mk(3'd5, 3'd0, 3'd0, 2'd0, 11'h020, 1'b1, 1'b0, 1'b0);

        for (int w = 0; w < 5000 && !(blk_done[0] && blk_done[1]); w++) @(posedge clk);
        check_val("all_blocks_done", 32'(blk_done[0] && blk_done[1]), 32'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
